// File: rtl/wb_dma_addr_cnt.sv
// wb_dma_addr_cnt
//   Per-channel DMA address / transfer counter. Holds the current word address,
//   the remaining beat count and the beats left in the current chunk. It
//   advances once per accepted bus beat and reports chunk boundaries and end of
//   transfer to the channel scheduler.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst       asynchronous reset, active-high
//   i_ld        load/start pulse (start address, total beats, chunk size)
//   i_ld_addr   start word address
//   i_ld_tot    total beats; 0 finishes immediately
//   i_ld_chk    beats per chunk; 0 disables chunking
//   i_inc_en    1 = address increments per beat, 0 = fixed address (FIFO)
//   i_adv       one beat accepted this cycle
//   i_resume    rearm after a chunk boundary
//   i_abort     cancel the transfer
//   o_addr      current word address
//   o_rem       beats remaining
//   o_busy      transfer in progress (RUN or CHUNK_WAIT)
//   o_chk_done  one-cycle pulse: chunk boundary reached
//   o_done      one-cycle pulse: transfer complete
//   o_wrap      sticky: address wrapped all-ones -> 0 since the last load
//
// state        | meaning
// S_IDLE       | no transfer; reset or aborted
// S_RUN        | counting beats
// S_CHUNK_WAIT | chunk finished, waiting for resume
// S_DONE       | transfer complete; address/count held until next load/abort
module wb_dma_addr_cnt #(
    parameter int AW = 30,
    parameter int TW = 12,
    parameter int CW = 9
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_ld,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [TW-1:0] i_ld_tot,
    input  logic [CW-1:0] i_ld_chk,
    input  logic          i_inc_en,
    input  logic          i_adv,
    input  logic          i_resume,
    input  logic          i_abort,
    output logic [AW-1:0] o_addr,
    output logic [TW-1:0] o_rem,
    output logic          o_busy,
    output logic          o_chk_done,
    output logic          o_done,
    output logic          o_wrap
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_RUN        = 2'd1,
        S_CHUNK_WAIT = 2'd2,
        S_DONE       = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [AW-1:0] r_addr;
    logic [TW-1:0] r_rem;
    logic [CW-1:0] r_chk_cnt;
    logic [CW-1:0] r_chk_ld;
    logic          r_wrap;
    logic          r_done;
    logic          r_chk_done;

    logic          w_beat;
    logic          w_chunk_en;
    logic [TW-1:0] w_rem_dec;
    logic [CW-1:0] w_chk_dec;
    logic          w_last_beat;
    logic          w_chunk_end;
    logic          w_done_nxt;
    logic          w_chk_done_nxt;

    // A beat counts only in RUN and only when nothing of higher priority is
    // present. The r_rem check keeps the count from ever underflowing.
    assign w_beat      = (r_state == S_RUN) && i_adv && !i_abort && !i_ld && (r_rem != '0);
    assign w_chunk_en  = (r_chk_ld != '0);
    assign w_rem_dec   = r_rem - TW'(1);
    assign w_chk_dec   = r_chk_cnt - CW'(1);
    assign w_last_beat = (w_rem_dec == '0);
    // End of transfer takes precedence over a coincident chunk boundary.
    assign w_chunk_end = w_chunk_en && (w_chk_dec == '0) && !w_last_beat;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b0;
            r_chk_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done     <= w_done_nxt;
            r_chk_done <= w_chk_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt    = r_state;
        w_done_nxt     = 1'b0;
        w_chk_done_nxt = 1'b0;
        if (i_abort) begin
            w_state_nxt = S_IDLE;
        end else if (i_ld) begin
            if (i_ld_tot == '0) begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end else begin
                w_state_nxt = S_RUN;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_beat) begin
                        if (w_last_beat) begin
                            w_state_nxt = S_DONE;
                            w_done_nxt  = 1'b1;
                        end else if (w_chunk_end) begin
                            w_state_nxt    = S_CHUNK_WAIT;
                            w_chk_done_nxt = 1'b1;
                        end
                    end
                end
                S_CHUNK_WAIT: begin
                    if (i_resume) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // Output decode
    always_comb begin
        o_busy     = (r_state == S_RUN) || (r_state == S_CHUNK_WAIT);
        o_addr     = r_addr;
        o_rem      = r_rem;
        o_done     = r_done;
        o_chk_done = r_chk_done;
        o_wrap     = r_wrap;
    end

    // Address, counters and wrap flag. Abort leaves them untouched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr    <= '0;
            r_rem     <= '0;
            r_chk_cnt <= '0;
            r_chk_ld  <= '0;
            r_wrap    <= 1'b0;
        end else if (!i_abort) begin
            if (i_ld) begin
                r_addr    <= i_ld_addr;
                r_rem     <= i_ld_tot;
                r_chk_cnt <= i_ld_chk;
                r_chk_ld  <= i_ld_chk;
                r_wrap    <= 1'b0;
            end else if ((r_state == S_CHUNK_WAIT) && i_resume) begin
                r_chk_cnt <= r_chk_ld;
            end else if (w_beat) begin
                r_rem <= w_rem_dec;
                if (i_inc_en) begin
                    r_addr <= r_addr + AW'(1);
                    if (&r_addr) begin
                        r_wrap <= 1'b1;
                    end
                end
                if (w_chunk_en) begin
                    r_chk_cnt <= w_chk_dec;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_dma_addr_cnt.sv
module tb_wb_dma_addr_cnt;

    localparam int AW = 30;
    localparam int TW = 12;
    localparam int CW = 9;
    localparam longint ADDR_SPAN = 64'd1 << AW;

    logic          clk;
    logic          rst;
    logic          ld;
    logic [AW-1:0] ld_addr;
    logic [TW-1:0] ld_tot;
    logic [CW-1:0] ld_chk;
    logic          inc_en;
    logic          adv;
    logic          resume;
    logic          abort;
    logic [AW-1:0] addr;
    logic [TW-1:0] rem;
    logic          busy;
    logic          chk_done;
    logic          done;
    logic          wrap;

    wb_dma_addr_cnt #(.AW(AW), .TW(TW), .CW(CW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ld       (ld),
        .i_ld_addr  (ld_addr),
        .i_ld_tot   (ld_tot),
        .i_ld_chk   (ld_chk),
        .i_inc_en   (inc_en),
        .i_adv      (adv),
        .i_resume   (resume),
        .i_abort    (abort),
        .o_addr     (addr),
        .o_rem      (rem),
        .o_busy     (busy),
        .o_chk_done (chk_done),
        .o_done     (done),
        .o_wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: transfer described by phase name and plain counters.
    string  m_phase;
    longint m_addr;
    int     m_rem;
    int     m_chunk_left;
    int     m_chunk_size;
    bit     m_wrap;
    bit     m_done;
    bit     m_chkd;

    int     n_done_seen;
    int     n_chkd_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase      = "idle";
        m_addr       = 0;
        m_rem        = 0;
        m_chunk_left = 0;
        m_chunk_size = 0;
        m_wrap       = 0;
        m_done       = 0;
        m_chkd       = 0;
    endtask

    // Applies the transfer rules for one clock using the inputs as driven now.
    task automatic model_step();
        m_done = 0;
        m_chkd = 0;
        if (abort) begin
            m_phase = "idle";
        end else if (ld) begin
            m_addr       = ld_addr;
            m_rem        = ld_tot;
            m_chunk_size = ld_chk;
            m_chunk_left = ld_chk;
            m_wrap       = 0;
            if (ld_tot == 0) begin
                m_phase = "done";
                m_done  = 1;
            end else begin
                m_phase = "run";
            end
        end else if (m_phase == "wait" && resume) begin
            m_phase      = "run";
            m_chunk_left = m_chunk_size;
        end else if (m_phase == "run" && adv) begin
            m_rem = m_rem - 1;
            if (inc_en) begin
                if (m_addr + 1 == ADDR_SPAN) m_wrap = 1;
                m_addr = (m_addr + 1) % ADDR_SPAN;
            end
            if (m_chunk_size != 0) m_chunk_left = m_chunk_left - 1;
            if (m_rem == 0) begin
                m_phase = "done";
                m_done  = 1;
            end else if (m_chunk_size != 0 && m_chunk_left == 0) begin
                m_phase = "wait";
                m_chkd  = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},     addr,     m_addr);
        check({tag, ".rem"},      rem,      m_rem);
        check({tag, ".busy"},     busy,     (m_phase == "run" || m_phase == "wait"));
        check({tag, ".done"},     done,     m_done);
        check({tag, ".chk_done"}, chk_done, m_chkd);
        check({tag, ".wrap"},     wrap,     m_wrap);
        if (done === 1'b1)     n_done_seen++;
        if (chk_done === 1'b1) n_chkd_seen++;
    endtask

    // Drives one cycle of inputs, advances the model, samples 1 time unit after the edge.
    task automatic drive(input string tag, input bit p_ld, input logic [AW-1:0] p_addr,
                         input int p_tot, input int p_chk, input bit p_inc,
                         input bit p_adv, input bit p_resume, input bit p_abort);
        ld      = p_ld;
        ld_addr = p_addr;
        ld_tot  = TW'(p_tot);
        ld_chk  = CW'(p_chk);
        inc_en  = p_inc;
        adv     = p_adv;
        resume  = p_resume;
        abort   = p_abort;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_cycle(input string tag);
        drive(tag, 0, '0, 0, 0, 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        ld = 0; ld_addr = '0; ld_tot = '0; ld_chk = '0;
        inc_en = 1; adv = 0; resume = 0; abort = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // 1: simple incrementing transfer, no chunking
        drive("t1_ld", 1, 30'h100, 4, 0, 1, 0, 0, 0);
        n_done_seen = 0;
        for (int i = 0; i < 4; i++) drive("t1_adv", 0, '0, 0, 0, 1, 1, 0, 0);
        check("t1_addr_end", addr, 30'h104);
        check("t1_done_cnt", n_done_seen, 1);
        idle_cycle("t1_hold");

        // 2: chunked transfer with adv held high; resume raised while waiting
        drive("t2_ld", 1, 30'h200, 6, 2, 1, 0, 0, 0);
        n_done_seen = 0;
        n_chkd_seen = 0;
        for (int i = 0; i < 12; i++)
            drive("t2_adv", 0, '0, 0, 0, 1, 1, (m_phase == "wait"), 0);
        check("t2_chk_cnt", n_chkd_seen, 2);
        check("t2_done_cnt", n_done_seen, 1);
        check("t2_addr_end", addr, 30'h206);

        // 3: address wrap
        drive("t3_ld", 1, 30'h3ffffffe, 3, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive("t3_adv", 0, '0, 0, 0, 1, 1, 0, 0);
        check("t3_addr_end", addr, 30'h1);
        check("t3_wrap", wrap, 1);
        idle_cycle("t3_hold");
        drive("t3_reld", 1, 30'h10, 2, 0, 1, 0, 0, 0);
        check("t3_wrap_clr", wrap, 0);

        // 4: fixed address, then zero-length load
        drive("t4_ld", 1, 30'h55, 3, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive("t4_adv", 0, '0, 0, 0, 0, 1, 0, 0);
        check("t4_addr_fixed", addr, 30'h55);
        drive("t4_ld0", 1, 30'h77, 0, 0, 1, 0, 0, 0);
        check("t4_done_ld0", done, 1);
        drive("t4_dn_adv", 0, '0, 0, 0, 1, 1, 1, 0);

        // 5: load beats adv, abort beats adv, async reset mid-run
        drive("t5_ld", 1, 30'h300, 8, 0, 1, 0, 0, 0);
        drive("t5_adv", 0, '0, 0, 0, 1, 1, 0, 0);
        drive("t5_ldadv", 1, 30'h400, 5, 0, 1, 1, 0, 0);
        check("t5_ld_wins", addr, 30'h400);
        drive("t5_adv2", 0, '0, 0, 0, 1, 1, 0, 0);
        drive("t5_abort", 0, '0, 0, 0, 1, 1, 0, 1);
        check("t5_abort_busy", busy, 0);
        drive("t5_idle_adv", 0, '0, 0, 0, 1, 1, 0, 0);
        drive("t5_ld3", 1, 30'h500, 10, 3, 1, 0, 0, 0);
        drive("t5_adv3", 0, '0, 0, 0, 1, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("t5_async_rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit          r_ld;
            logic [AW-1:0] r_addr;
            r_ld = ($urandom_range(0, 15) == 0) || (m_phase == "idle" && $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0)
                r_addr = 30'h3ffffff0 + AW'($urandom_range(0, 15));
            else
                r_addr = AW'($urandom);
            drive("rnd", r_ld, r_addr, $urandom_range(0, 20), $urandom_range(0, 5),
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 60) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
